gaussian_filter_3x3: RTL and testbench
======================================

# gaussian_filter_3x3

Streaming 3x3 Gaussian blur stage that consumes the cropped pixel stream emitted by the crop+FIFO stage and produces a blurred image, one pixel per accepted input at full throughput. Uses two line buffers and a 3x3 window, valid-only convolution (no border padding), so each IN_ROWS x IN_COLS frame yields (IN_ROWS-2) x (IN_COLS-2) output pixels in raster order. Valid/ready handshake on both sides, compatible with the upstream FIFO output.

## Interface
- PIXEL_BIT_WIDTH, 12, bits per unsigned pixel
- IN_ROWS, 20, rows per input frame (>= 3)
- IN_COLS, 20, columns per input frame (>= 3)
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-low reset
- pixel_in  input  PIXEL_BIT_WIDTH  input pixel, raster order
- in_valid  input  1  pixel_in valid
- in_ready  output  1  block can accept pixel_in this cycle
- pixel_out  output  PIXEL_BIT_WIDTH  blurred pixel
- out_valid  output  1  pixel_out valid
- out_ready  input  1  downstream accepts pixel_out

## Operation
- Kernel [1 2 1; 2 4 2; 1 2 1] / 16. Sum width PIXEL_BIT_WIDTH+4; result = (sum + 8) >> 4. Max result equals max input, no saturation needed.
- Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Counters row (0..IN_ROWS-1), col (0..IN_COLS-1) advance on each input transfer; col wraps to 0 and row increments at col==IN_COLS-1; row wraps to 0 at end of frame, next frame begins immediately.
- Line buffers: LB0 holds previous row, LB1 the row before; on input transfer at col c, LB1[c] <= LB0[c], LB0[c] <= pixel_in.
- Window: 3 columns x 3 rows; on input transfer shift left, new column = {LB1[c], LB0[c], pixel_in}.
- Emit: transfer at (row>=2, col>=2) produces output for window centered at (row-1, col-1); computed from the updated window, registered into pixel_out.
- Window contents spanning a row wrap (col<2) or the first two rows are never emitted; line buffers are not cleared between frames.

## Timing
- Reset (reset==0 at clk edge): out_valid=0, pixel_out=0, row=col=0, window cleared; in_ready=1 in the cycle after reset deasserts.
- in_ready = !out_valid || out_ready (combinational, single output register, no skid buffer).
- Latency: pixel_out/out_valid valid the cycle after the completing input transfer.
- Backpressure: while out_valid && !out_ready, pixel_out and out_valid hold stable, in_ready=0, no counter/buffer/window change.
- Simultaneous output transfer and input transfer: output register reloads (out_valid stays 1 if new pixel emits, else drops to 0); sustained 1 pixel/cycle.
- Input transfer not emitting (border) with no pending output: out_valid stays 0.
- Reset mid-frame: partial frame and pending output discarded; next accepted pixel is (0,0).
- Per frame exactly (IN_ROWS-2)*(IN_COLS-2) outputs; first at input (2,2), last at (IN_ROWS-1, IN_COLS-1).

## Structure
- Shared package gaussian_pkg: kernel weights, normalisation shift (4), rounding constant (8), sum-width helper.
- One sub-module: line_buffer (parameters DATA_WIDTH, DEPTH; single-port read-before-write at column address, write enable = input transfer). Instantiated twice.
- Top holds counters, window registers, adder tree, output register, handshake.

## Test plan
- Constant frame 20x20 of value 100, out_ready=1 -> 324 outputs all 100, first out_valid one cycle after 43rd input (pixel (2,2)).
- Impulse 16 at input (5,5), rest 0 -> output centered (5,5)=4; (4,5),(6,5),(5,4),(5,6)=2; diagonals=1; all others 0.
- Rounding: single pixel 2 at (5,5) -> center output (8+8)>>4=1; single pixel 1 -> all outputs 0. All-4095 frame -> all outputs 4095.
- Random out_ready (50%) and random in_valid gaps on random image -> output sequence identical to golden model, pixel_out stable during stalls, no loss/duplication.
- Two back-to-back frames with no idle cycle -> 648 outputs, second frame matches golden model independent of first.
- Assert reset (low one cycle) mid-row 7 with out_valid=1 -> out_valid=0 next cycle; fresh full frame afterward gives exactly 324 correct outputs.

Source files
------------

// File: rtl/gaussian_pkg.sv
// Shared constants for the 3x3 Gaussian blur: kernel weights, normalisation
// and rounding, plus the accumulator width helper.
package gaussian_pkg;

    localparam int NORM_SHIFT  = 4;   // kernel weights sum to 16
    localparam int ROUND_CONST = 8;   // half of 16, round-to-nearest

    // Kernel indexed [row][col], row 0 = oldest row in the window.
    localparam int unsigned KERNEL [3][3] = '{'{1, 2, 1},
                                              '{2, 4, 2},
                                              '{1, 2, 1}};

    // Weighted sum of nine pixels never exceeds 16 * max pixel.
    function automatic int sum_width(input int pix_w);
        return pix_w + NORM_SHIFT;
    endfunction

endpackage

// File: rtl/gaussian_filter_3x3_if.sv
// Pixel stream interface: input stream (pixel_in/in_valid/in_ready) and
// output stream (pixel_out/out_valid/out_ready) of the blur stage.
interface gaussian_filter_3x3_if #(
    parameter int PIXEL_BIT_WIDTH = 12
);
    logic [PIXEL_BIT_WIDTH-1:0] pixel_in;
    logic                       in_valid;
    logic                       in_ready;
    logic [PIXEL_BIT_WIDTH-1:0] pixel_out;
    logic                       out_valid;
    logic                       out_ready;

    // Filter side.
    modport slave (
        input  pixel_in, in_valid, out_ready,
        output in_ready, pixel_out, out_valid
    );

    // Producer/consumer side.
    modport master (
        output pixel_in, in_valid, out_ready,
        input  in_ready, pixel_out, out_valid
    );
endinterface

// File: rtl/gaussian_filter_3x3_line_buffer.sv
// One image row of storage, addressed by column. Read is combinational and
// returns the old contents, so a write at the same address in the same cycle
// behaves as read-before-write.
module line_buffer #(
    parameter  int DATA_WIDTH = 12,
    parameter  int DEPTH      = 20,
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    // Contents are deliberately not reset: stale rows are never emitted.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    assign rd_data = mem_q[addr];

    // Store the incoming pixel on every accepted input.
    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wr_data;
    end

endmodule

// File: rtl/gaussian_filter_3x3.sv
// Streaming 3x3 Gaussian blur, valid-only convolution. One pixel per accepted
// input; a single output register with pass-through ready.
module gaussian_filter_3x3
    import gaussian_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH = 12,
    parameter int IN_ROWS         = 20,
    parameter int IN_COLS         = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    gaussian_filter_3x3_if.slave  bus
);

    localparam int W  = PIXEL_BIT_WIDTH;
    localparam int SW = sum_width(PIXEL_BIT_WIDTH);
    localparam int RW = $clog2(IN_ROWS);
    localparam int CW = $clog2(IN_COLS);

    logic [RW-1:0]           row_q, row_d;
    logic [CW-1:0]           col_q, col_d;
    logic [2:0][2:0][W-1:0]  win_q, win_d;     // [row][col], row 2 = current row
    logic                    out_valid_q, out_valid_d;
    logic [W-1:0]            pixel_out_q, pixel_out_d;

    logic                    xfer_in;
    logic                    emit;
    logic [W-1:0]            lb0_rd, lb1_rd;
    logic [SW-1:0]           sum;
    logic [SW-1:0]           rounded;
    logic [W-1:0]            result;

    // The output register can take a new pixel whenever it is empty or drains now.
    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.pixel_out = pixel_out_q;
    assign bus.out_valid = out_valid_q;

    assign xfer_in = bus.in_valid && bus.in_ready;
    // Only windows fully inside the frame produce output.
    assign emit    = xfer_in && (row_q >= RW'(2)) && (col_q >= CW'(2));

    // LB0 holds the previous row, LB1 the row before; LB1 takes LB0's old value.
    line_buffer #(.DATA_WIDTH(W), .DEPTH(IN_COLS)) u_lb0 (
        .clk     (clk),
        .we      (xfer_in),
        .addr    (col_q),
        .wr_data (bus.pixel_in),
        .rd_data (lb0_rd)
    );

    line_buffer #(.DATA_WIDTH(W), .DEPTH(IN_COLS)) u_lb1 (
        .clk     (clk),
        .we      (xfer_in),
        .addr    (col_q),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    // Raster position of the next input pixel.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (xfer_in) begin
            if (col_q == CW'(IN_COLS - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IN_ROWS - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Shift the window left and bring in the new column {LB1, LB0, pixel_in}.
    always_comb begin
        win_d = win_q;
        if (xfer_in) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_rd;
            win_d[1][2] = lb0_rd;
            win_d[2][2] = bus.pixel_in;
        end
    end

    // Weighted sum over the updated window, then round and normalise.
    always_comb begin
        sum = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                sum = sum + SW'(win_d[r][c]) * SW'(KERNEL[r][c]);
            end
        end
        rounded = sum + SW'(ROUND_CONST);
        result  = rounded[SW-1:NORM_SHIFT];
    end

    // Output register: reload on input transfer, clear when drained, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        pixel_out_d = pixel_out_q;
        if (xfer_in) begin
            out_valid_d = emit;
            if (emit) pixel_out_d = result;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            row_q       <= '0;
            col_q       <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            pixel_out_q <= '0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            win_q       <= win_d;
            out_valid_q <= out_valid_d;
            pixel_out_q <= pixel_out_d;
        end
    end

endmodule

// File: tb/tb_gaussian_filter_3x3.sv
// Bench for gaussian_filter_3x3: stimulus frames streamed with random
// handshakes, outputs compared to a direct convolution of the frame.
module tb_gaussian_filter_3x3;

    localparam int W = 12;
    localparam int R = 20;
    localparam int C = 20;
    localparam int NOUT = (R - 2) * (C - 2);
    localparam int BUDGET = 20000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gaussian_filter_3x3_if #(.PIXEL_BIT_WIDTH(W)) bus ();

    gaussian_filter_3x3 #(.PIXEL_BIT_WIDTH(W), .IN_ROWS(R), .IN_COLS(C)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [W-1:0] frame [R][C];
    logic [W-1:0] stim[$];
    logic [W-1:0] expq[$];
    logic [W-1:0] gotq[$];
    int stall_viol, first_out_cyc, xfer42_cyc;
    bit timed_out;

    // Reference: blur of the frame straight from the kernel definition.
    function automatic void push_frame();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) stim.push_back(frame[r][c]);
        for (int r = 1; r < R - 1; r++) begin
            for (int c = 1; c < C - 1; c++) begin
                int s = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        s += ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1) * int'(frame[r+dr][c+dc]);
                expq.push_back(W'((s + 8) / 16));
            end
        end
    endfunction

    function automatic void fill_const(input int v);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) frame[r][c] = W'(v);
    endfunction

    function automatic void fill_rand();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) frame[r][c] = W'($urandom_range(4095));
    endfunction

    function automatic int first_mismatch();
        int n = (gotq.size() < expq.size()) ? gotq.size() : expq.size();
        for (int i = 0; i < n; i++) if (gotq[i] !== expq[i]) return i;
        return -1;
    endfunction

    // Stream stim[] through the DUT with the given valid/ready percentages,
    // collecting accepted outputs and counting any change during a stall.
    task automatic run_stream(input int vpct, input int rpct);
        int idx = 0;
        int cyc = 0;
        logic hold = 1'b0;
        logic [W-1:0] held = '0;
        gotq.delete();
        stall_viol = 0; first_out_cyc = -1; xfer42_cyc = -1; timed_out = 0;
        while ((idx < stim.size() || gotq.size() < expq.size()) && cyc < BUDGET) begin
            @(posedge clk); #1;
            bus.in_valid  = (idx < stim.size()) && ($urandom_range(99) < vpct);
            bus.pixel_in  = (idx < stim.size()) ? stim[idx] : '0;
            bus.out_ready = ($urandom_range(99) < rpct);
            @(negedge clk);
            if (hold && (!bus.out_valid || bus.pixel_out !== held)) stall_viol++;
            if (bus.out_valid && first_out_cyc < 0) first_out_cyc = cyc;
            hold = bus.out_valid && !bus.out_ready;
            held = bus.pixel_out;
            if (bus.out_valid && bus.out_ready) gotq.push_back(bus.pixel_out);
            if (bus.in_valid && bus.in_ready) begin
                if (idx == 42) xfer42_cyc = cyc;
                idx++;
            end
            cyc++;
        end
        timed_out = (cyc >= BUDGET);
        // Idle drain so spurious extra outputs show up in the count.
        repeat (4) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0; bus.out_ready = 1'b1;
            @(negedge clk);
            if (bus.out_valid) gotq.push_back(bus.pixel_out);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.pixel_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.pixel_out !== '0) begin errors++; $display("FAIL reset_pixel_out: got %0d want 0", bus.pixel_out); end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_constant();
        int m;
        stim.delete(); expq.delete();
        fill_const(100); push_frame();
        run_stream(100, 100);
        checks++; if (timed_out || gotq.size() != NOUT) begin errors++; $display("FAIL const_count: got %0d want %0d", gotq.size(), NOUT); end
        m = -1;
        foreach (gotq[i]) if (gotq[i] !== W'(100) && m < 0) m = i;
        checks++; if (m >= 0) begin errors++; $display("FAIL const_value: out[%0d]=%0d want 100", m, gotq[m]); end
        checks++; if (xfer42_cyc < 0 || first_out_cyc != xfer42_cyc + 1) begin errors++; $display("FAIL const_latency: first out cycle %0d want %0d", first_out_cyc, xfer42_cyc + 1); end
    endtask

    task automatic test_impulse();
        int m;
        stim.delete(); expq.delete();
        fill_const(0); frame[5][5] = 16; push_frame();
        run_stream(100, 100);
        checks++; if (timed_out || gotq.size() != NOUT) begin errors++; $display("FAIL imp_count: got %0d want %0d", gotq.size(), NOUT); end
        checks++; if (gotq[4*18+4] !== W'(4)) begin errors++; $display("FAIL imp_center: got %0d want 4", gotq[4*18+4]); end
        checks++; if (gotq[3*18+4] !== W'(2) || gotq[4*18+3] !== W'(2)) begin errors++; $display("FAIL imp_edge: got %0d,%0d want 2,2", gotq[3*18+4], gotq[4*18+3]); end
        checks++; if (gotq[3*18+3] !== W'(1) || gotq[5*18+5] !== W'(1)) begin errors++; $display("FAIL imp_diag: got %0d,%0d want 1,1", gotq[3*18+3], gotq[5*18+5]); end
        m = first_mismatch();
        checks++; if (m >= 0) begin errors++; $display("FAIL imp_model: out[%0d]=%0d want %0d", m, gotq[m], expq[m]); end
    endtask

    task automatic test_rounding();
        int s = 0;
        stim.delete(); expq.delete();
        fill_const(0); frame[5][5] = 2; push_frame();
        run_stream(100, 100);
        checks++; if (gotq.size() != NOUT || gotq[4*18+4] !== W'(1)) begin errors++; $display("FAIL round_two: got %0d want 1 (n=%0d)", gotq[4*18+4], gotq.size()); end
        stim.delete(); expq.delete();
        fill_const(0); frame[5][5] = 1; push_frame();
        run_stream(100, 100);
        foreach (gotq[i]) s += int'(gotq[i]);
        checks++; if (gotq.size() != NOUT || s != 0) begin errors++; $display("FAIL round_one: sum %0d want 0 (n=%0d)", s, gotq.size()); end
    endtask

    task automatic test_full_scale();
        int m = -1;
        stim.delete(); expq.delete();
        fill_const(4095); push_frame();
        run_stream(100, 100);
        foreach (gotq[i]) if (gotq[i] !== W'(4095) && m < 0) m = i;
        checks++; if (gotq.size() != NOUT || m >= 0) begin errors++; $display("FAIL full_scale: n=%0d first bad idx %0d want all 4095", gotq.size(), m); end
    endtask

    task automatic test_random_stall();
        int m;
        stim.delete(); expq.delete();
        fill_rand(); push_frame();
        run_stream(70, 50);
        checks++; if (timed_out || gotq.size() != NOUT) begin errors++; $display("FAIL rand_count: got %0d want %0d", gotq.size(), NOUT); end
        m = first_mismatch();
        checks++; if (m >= 0) begin errors++; $display("FAIL rand_model: out[%0d]=%0d want %0d", m, gotq[m], expq[m]); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL rand_stall_hold: %0d changes want 0", stall_viol); end
    endtask

    task automatic test_back_to_back();
        int m;
        stim.delete(); expq.delete();
        fill_rand(); push_frame();
        fill_rand(); push_frame();
        run_stream(100, 100);
        checks++; if (timed_out || gotq.size() != 2 * NOUT) begin errors++; $display("FAIL b2b_count: got %0d want %0d", gotq.size(), 2 * NOUT); end
        m = first_mismatch();
        checks++; if (m >= 0) begin errors++; $display("FAIL b2b_model: out[%0d]=%0d want %0d", m, gotq[m], expq[m]); end
    endtask

    task automatic test_mid_reset();
        int idx = 0;
        int m;
        int guard = 0;
        stim.delete(); expq.delete();
        fill_rand(); push_frame();
        while (idx < 7 * C + 6 && guard < 1000) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1; bus.pixel_in = stim[idx]; bus.out_ready = 1'b1;
            @(negedge clk);
            if (bus.in_ready) idx++;
            guard++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre: out_valid %b want 1", bus.out_valid); end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_post: out_valid %b in_ready %b want 0 1", bus.out_valid, bus.in_ready); end
        stim.delete(); expq.delete();
        fill_rand(); push_frame();
        run_stream(100, 100);
        checks++; if (timed_out || gotq.size() != NOUT) begin errors++; $display("FAIL midrst_count: got %0d want %0d", gotq.size(), NOUT); end
        m = first_mismatch();
        checks++; if (m >= 0) begin errors++; $display("FAIL midrst_model: out[%0d]=%0d want %0d", m, gotq[m], expq[m]); end
    endtask

    initial begin
        reset = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.pixel_in = '0;
        test_reset();
        test_constant();
        test_impulse();
        test_rounding();
        test_full_scale();
        test_random_stall();
        do_reset();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
